contador_descendente_bcd: RTL and testbench
===========================================

// Module: contador_descendente_bcd
// PURPOSE
//  Loadable multi-digit BCD down-counter with floor saturation; the counting-down
//  counterpart of our saturating up-counters. Accepts a preset via valid/ready,
//  subtracts a per-cycle BCD step while enabled, saturates at FLOOR, pulses o_Done.
//  Drives countdown/timeout displays beside the up-counters in the display datapath.
// PARAMETERS
//  DIGITS  2      number of BCD digits (value width 4*DIGITS)
//  FLOOR   0      saturation floor, integer, 0 <= FLOOR <= 10**DIGITS-1
// PORTS
//  i_Clk        in   1          system clock, rising edge
//  i_GRst       in   1          asynchronous, active-low reset
//  i_En         in   1          count enable; RUN decrements only when high
//  i_LoadValid  in   1          preset valid
//  o_LoadReady  out  1          preset accepted when i_LoadValid & o_LoadReady
//  i_Preset     in   4*DIGITS   BCD preset value
//  i_Step       in   4          BCD decrement per enabled cycle (0..9)
//  o_Q          out  4*DIGITS   current BCD count (registered)
//  o_Busy       out  1          high in RUN
//  o_Zero       out  1          high when o_Q == FLOOR (registered)
//  o_Done       out  1          one-cycle pulse on reaching FLOOR
// BEHAVIOUR
//  Reset (i_GRst=0, async): state=IDLE, o_Q=FLOOR, o_Zero=1, o_Busy=0, o_Done=0,
//   o_LoadReady=1 after release. Reset mid-RUN aborts immediately, no o_Done.
//  States: IDLE -> RUN -> DONE -> IDLE.
//  IDLE: o_LoadReady=1; o_Q holds. On handshake: o_Q<=sanitised preset next edge;
//   sanitised preset <= FLOOR -> o_Q<=FLOOR, go DONE; else go RUN.
//  Preset sanitising: any digit >9 clamped to 9 per digit before compare/store.
//  RUN: o_LoadReady=0, o_Busy=1. i_En=0 -> hold. i_En=1 -> o_Q<=o_Q-step where
//   step = min(i_Step,9); decimal borrow ripples digit to digit, LSD first.
//   If o_Q-step <= FLOOR (incl. would-underflow) -> o_Q<=FLOOR, go DONE.
//   step=0 with i_En=1 holds o_Q, stays RUN.
//  DONE: exactly one cycle; o_Done=1, o_Busy=0, o_LoadReady=0; then IDLE.
//  Latency: handshake edge N -> o_Q valid after N; first decrement earliest N+1;
//   o_Done high the cycle after the edge where o_Q became FLOOR.
//  i_LoadValid outside IDLE ignored (no queueing). o_Zero tracks o_Q==FLOOR
//   in every state. All outputs registered; no comb path input->output.
// CONFIGURATION
//  AUTO_RELOAD_EN defined: last accepted sanitised preset kept in shadow reg;
//   DONE -> RUN with o_Q<=shadow (o_Done still pulses one cycle), so the block
//   counts periodically until a reset; o_LoadReady stays 0 outside IDLE, so
//   IDLE is reached only after reset, and the first handshake there starts the
//   cycle. Shadow <= FLOOR: DONE -> IDLE as normal.
//  Not defined: no shadow register; DONE always -> IDLE.
// TESTING
//  1 Reset: drive i_GRst=0 mid-cycle -> o_Q=8'h00, o_Zero=1, o_Busy=0 without edge.
//  2 Load 8'h25, step 1, i_En=1 -> o_Q 25,24,...,01,00; o_Done one pulse after 00;
//    o_LoadReady=1 again next cycle.
//  3 Borrow/saturate: load 8'h12, step 7 -> 05, then 00 (saturated), o_Done=1.
//  4 Enable gaps: load 8'h10, toggle i_En 1,0,0,1 -> 09,09,09,08; step 0 holds.
//  5 Sanitise/edge: load 8'hFA -> o_Q=8'h99; load 8'h00 -> DONE directly, o_Done=1;
//    i_LoadValid during RUN ignored, o_Q unaffected.
//  6 AUTO_RELOAD_EN, FLOOR=3: load 8'h05, step 1 -> 05,04,03,(Done) 05,04,03...;
//    reset mid-count -> o_Q=8'h03, IDLE, no o_Done.

Source files
------------

// File: rtl/contador_descendente_bcd_if.sv
// Handshake and data bundle for contador_descendente_bcd.
// master drives the preset/step/enable side, slave is the counter itself.
interface contador_descendente_bcd_if #(
  parameter int DIGITS = 2
) ();
  logic                  i_En;
  logic                  i_LoadValid;
  logic                  o_LoadReady;
  logic [4*DIGITS-1:0]   i_Preset;
  logic [3:0]            i_Step;
  logic [4*DIGITS-1:0]   o_Q;
  logic                  o_Busy;
  logic                  o_Zero;
  logic                  o_Done;

  modport master (
    output i_En, i_LoadValid, i_Preset, i_Step,
    input  o_LoadReady, o_Q, o_Busy, o_Zero, o_Done
  );

  modport slave (
    input  i_En, i_LoadValid, i_Preset, i_Step,
    output o_LoadReady, o_Q, o_Busy, o_Zero, o_Done
  );
endinterface

// File: rtl/contador_descendente_bcd.sv
// Loadable multi-digit BCD down-counter saturating at FLOOR, with a one-cycle done pulse.
// Define AUTO_RELOAD_EN to reload the last accepted preset after each DONE (periodic mode).
module contador_descendente_bcd #(
  parameter int DIGITS = 2,
  parameter int FLOOR  = 0
) (
  input  logic                       i_Clk,
  input  logic                       i_GRst,
  contador_descendente_bcd_if.slave  bus
);
  localparam int W = 4 * DIGITS;

  function automatic logic [W-1:0] to_bcd(input int unsigned v);
    logic [W-1:0] r;
    int unsigned  t;
    r = '0;
    t = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  localparam logic [W-1:0] FLOOR_BCD = to_bcd(FLOOR);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]    state_reg, state_next;
  logic [W-1:0]  q_reg, q_next;
  logic          ready_reg, busy_reg, done_reg, zero_reg;
  logic [W-1:0]  preset_s;
  logic [W-1:0]  diff;
  logic [DIGITS:0] borrow;
  logic [3:0]    step_c;
  logic          load_fire;

`ifdef AUTO_RELOAD_EN
  logic [W-1:0]  shadow_reg, shadow_next;
`endif

  assign step_c    = (bus.i_Step > 4'd9) ? 4'd9 : bus.i_Step;
  assign load_fire = bus.i_LoadValid & ready_reg;
  assign borrow[0] = 1'b0;

  // Per-digit preset clamp and ripple-borrow subtractor; step only enters the LSD.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic [3:0] pre_d;
      logic [3:0] sub_d;
      logic [4:0] raw;

      assign pre_d = bus.i_Preset[4*gi +: 4];
      assign preset_s[4*gi +: 4] = (pre_d > 4'd9) ? 4'd9 : pre_d;

      if (gi == 0) begin : g_lsd
        assign sub_d = step_c;
      end else begin : g_upper
        assign sub_d = 4'd0;
      end

      assign raw = {1'b0, q_reg[4*gi +: 4]} - {1'b0, sub_d} - {4'd0, borrow[gi]};
      assign borrow[gi+1] = raw[4];
      assign diff[4*gi +: 4] = raw[4] ? (raw[3:0] + 4'd10) : raw[3:0];
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    q_next     = q_reg;
`ifdef AUTO_RELOAD_EN
    shadow_next = shadow_reg;
`endif
    case (state_reg)
      ST_IDLE: begin
        if (load_fire) begin
`ifdef AUTO_RELOAD_EN
          shadow_next = preset_s;
`endif
          if (preset_s <= FLOOR_BCD) begin
            q_next     = FLOOR_BCD;
            state_next = ST_DONE;
          end else begin
            q_next     = preset_s;
            state_next = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        // A borrow out of the MSD means the subtraction wrapped below zero.
        if (bus.i_En && (step_c != 4'd0)) begin
          if (borrow[DIGITS] || (diff <= FLOOR_BCD)) begin
            q_next     = FLOOR_BCD;
            state_next = ST_DONE;
          end else begin
            q_next     = diff;
          end
        end
      end
      ST_DONE: begin
`ifdef AUTO_RELOAD_EN
        if (shadow_reg > FLOOR_BCD) begin
          q_next     = shadow_reg;
          state_next = ST_RUN;
        end else begin
          state_next = ST_IDLE;
        end
`else
        state_next = ST_IDLE;
`endif
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Status flags are derived from the next state so every output stays registered.
  always_ff @(posedge i_Clk or negedge i_GRst) begin
    if (!i_GRst) begin
      state_reg <= ST_IDLE;
      q_reg     <= FLOOR_BCD;
      zero_reg  <= 1'b1;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      ready_reg <= 1'b1;
    end else begin
      state_reg <= state_next;
      q_reg     <= q_next;
      zero_reg  <= (q_next == FLOOR_BCD);
      busy_reg  <= (state_next == ST_RUN);
      done_reg  <= (state_next == ST_DONE);
      ready_reg <= (state_next == ST_IDLE);
    end
  end

`ifdef AUTO_RELOAD_EN
  always_ff @(posedge i_Clk or negedge i_GRst) begin
    if (!i_GRst) begin
      shadow_reg <= FLOOR_BCD;
    end else begin
      shadow_reg <= shadow_next;
    end
  end
`endif

  assign bus.o_Q         = q_reg;
  assign bus.o_Zero      = zero_reg;
  assign bus.o_Busy      = busy_reg;
  assign bus.o_Done      = done_reg;
  assign bus.o_LoadReady = ready_reg;
endmodule

// File: tb/tb_contador_descendente_bcd.sv
// Directed bench for contador_descendente_bcd: an integer reference model feeds a scoreboard queue.
// Built with AUTO_RELOAD_EN it runs the periodic-reload sequence with FLOOR=3 instead.
module tb_contador_descendente_bcd;
`ifdef AUTO_RELOAD_EN
  localparam int FLOOR = 3;
  localparam bit AUTO  = 1'b1;
`else
  localparam int FLOOR = 0;
  localparam bit AUTO  = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  contador_descendente_bcd_if #(.DIGITS(2)) bif ();

  contador_descendente_bcd #(.DIGITS(2), .FLOOR(FLOOR)) dut (
    .i_Clk  (clk),
    .i_GRst (rst_n),
    .bus    (bif)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] q;
    logic [3:0] flags;  // {busy, done, ready, zero}
  } exp_t;

  exp_t exp_q[$];
  int   total  = 0;
  int   passed = 0;
  int   ticks  = 0;
  int   m_st   = 0;   // 0 idle, 1 run, 2 done
  int   m_val  = FLOOR;
  int   m_shadow = FLOOR;

  function automatic logic [7:0] int2bcd(input int v);
    logic [3:0] t;
    logic [3:0] u;
    t = 4'(v / 10);
    u = 4'(v % 10);
    return {t, u};
  endfunction

  function automatic int sanit(input logic [7:0] b);
    int hi;
    int lo;
    hi = (b[7:4] > 4'd9) ? 9 : int'(b[7:4]);
    lo = (b[3:0] > 4'd9) ? 9 : int'(b[3:0]);
    return hi * 10 + lo;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %h required %h", tag, obs, expv);
  endtask

  task automatic model_edge(input logic en, input logic lv, input logic [7:0] pre,
                            input logic [3:0] step);
    int p;
    int s;
    case (m_st)
      0: if (lv) begin
        p = sanit(pre);
        m_shadow = p;
        if (p <= FLOOR) begin m_val = FLOOR; m_st = 2; end
        else begin m_val = p; m_st = 1; end
      end
      1: if (en) begin
        s = (step > 4'd9) ? 9 : int'(step);
        if (m_val - s <= FLOOR) begin m_val = FLOOR; m_st = 2; end
        else m_val = m_val - s;
      end
      default: begin
        if (AUTO && m_shadow > FLOOR) begin m_val = m_shadow; m_st = 1; end
        else m_st = 0;
      end
    endcase
  endtask

  function automatic logic [7:0] dut_flags();
    return {4'b0, bif.o_Busy, bif.o_Done, bif.o_LoadReady, bif.o_Zero};
  endfunction

  task automatic tick(input string tag, input logic en, input logic lv,
                      input logic [7:0] pre, input logic [3:0] step);
    exp_t e;
    bif.i_En = en;
    bif.i_LoadValid = lv;
    bif.i_Preset = pre;
    bif.i_Step = step;
    model_edge(en, lv, pre, step);
    e.q     = int2bcd(m_val);
    e.flags = {m_st == 1, m_st == 2, m_st == 0, m_val == FLOOR};
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    ticks++;
    chk({tag, "_q"}, bif.o_Q, e.q);
    chk({tag, "_flags"}, dut_flags(), {4'b0, e.flags});
    $display("tick %0d %s en=%b lv=%b preset=%h step=%h -> q=%h flags=%b", ticks, tag,
             en, lv, pre, step, bif.o_Q, dut_flags());
  endtask

  // Asynchronous reset asserted mid-cycle, checked before any clock edge.
  task automatic mid_reset(input string tag);
    #3;
    rst_n = 1'b0;
    #1;
    chk({tag, "_async_q"}, bif.o_Q, int2bcd(FLOOR));
    chk({tag, "_async_flags"}, dut_flags(), 8'b0000_0011);
    m_st = 0;
    m_val = FLOOR;
    bif.i_En = 1'b0;
    bif.i_LoadValid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bif.i_En = 1'b0;
    bif.i_LoadValid = 1'b0;
    bif.i_Preset = 8'h00;
    bif.i_Step = 4'h0;
    #7;
    chk("reset_q", bif.o_Q, int2bcd(FLOOR));
    chk("reset_flags", dut_flags(), 8'b0000_0011);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

`ifdef AUTO_RELOAD_EN
    begin
      logic [7:0] seq_q [6];
      logic [7:0] seq_d [6];
      seq_q = '{8'h04, 8'h03, 8'h05, 8'h04, 8'h03, 8'h05};
      seq_d = '{8'h00, 8'h01, 8'h00, 8'h00, 8'h01, 8'h00};
      tick("ar_load05", 1'b0, 1'b1, 8'h05, 4'h0);
      for (int i = 0; i < 6; i++) begin
        tick("ar_count", 1'b1, 1'b0, 8'h00, 4'h1);
        chk("ar_seq_q", bif.o_Q, seq_q[i]);
        chk("ar_seq_done", {7'b0, bif.o_Done}, seq_d[i]);
      end
      tick("ar_count", 1'b1, 1'b1, 8'h09, 4'h1);
      mid_reset("ar_midrst");
      chk("ar_after_rst_q", bif.o_Q, 8'h03);
      chk("ar_after_rst_flags", dut_flags(), 8'b0000_0011);
    end
`else
    begin
      int done_seen;
      // Full countdown from 25 by 1.
      tick("load25", 1'b0, 1'b1, 8'h25, 4'h0);
      done_seen = 0;
      for (int i = 0; i < 40 && m_st != 0; i++) begin
        tick("cnt25", 1'b1, 1'b0, 8'h00, 4'h1);
        if (bif.o_Done) done_seen++;
      end
      chk("cnt25_bound", {7'b0, m_st == 0}, 8'h01);
      chk("cnt25_done_pulses", 8'(done_seen), 8'h01);

      // Decimal borrow then saturation.
      tick("load12", 1'b0, 1'b1, 8'h12, 4'h0);
      tick("step7a", 1'b1, 1'b0, 8'h00, 4'h7);
      chk("borrow_05", bif.o_Q, 8'h05);
      tick("step7b", 1'b1, 1'b0, 8'h00, 4'h7);
      chk("sat_done", {7'b0, bif.o_Done}, 8'h01);
      tick("idle12", 1'b0, 1'b0, 8'h00, 4'h0);

      // Enable gaps, zero step, and underflow from 08 by 9.
      tick("load10", 1'b0, 1'b1, 8'h10, 4'h0);
      tick("gap_en1", 1'b1, 1'b0, 8'h00, 4'h1);
      tick("gap_en0a", 1'b0, 1'b0, 8'h00, 4'h1);
      tick("gap_en0b", 1'b0, 1'b0, 8'h00, 4'h1);
      tick("gap_en1b", 1'b1, 1'b0, 8'h00, 4'h1);
      chk("gap_08", bif.o_Q, 8'h08);
      tick("step0", 1'b1, 1'b0, 8'h00, 4'h0);
      tick("under9", 1'b1, 1'b0, 8'h00, 4'h9);
      tick("idle10", 1'b0, 1'b0, 8'h00, 4'h0);

      // Preset sanitising, oversize step, ignored load during RUN.
      tick("loadFA", 1'b0, 1'b1, 8'hFA, 4'h0);
      chk("sanit_99", bif.o_Q, 8'h99);
      tick("stepC", 1'b1, 1'b0, 8'h00, 4'hC);
      tick("ign_load", 1'b0, 1'b1, 8'h50, 4'h1);
      chk("ign_load_90", bif.o_Q, 8'h90);
      for (int i = 0; i < 40 && m_st != 0; i++) tick("drain", 1'b1, 1'b0, 8'h00, 4'h9);
      chk("drain_bound", {7'b0, m_st == 0}, 8'h01);
      tick("load00", 1'b0, 1'b1, 8'h00, 4'h0);
      chk("load00_done", {7'b0, bif.o_Done}, 8'h01);
      tick("idle00", 1'b0, 1'b0, 8'h00, 4'h0);

      // Reset in the middle of a run: no done pulse afterwards.
      tick("load37", 1'b0, 1'b1, 8'h37, 4'h0);
      tick("cnt37", 1'b1, 1'b0, 8'h00, 4'h1);
      mid_reset("midrst");
      chk("midrst_nodone", {7'b0, bif.o_Done}, 8'h00);
      tick("post_rst", 1'b0, 1'b0, 8'h00, 4'h0);
    end
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
